div_iter: RTL and testbench



---
 rtl/multdiv_pkg.sv | 14 +
 rtl/adder_32.sv | 14 +
 rtl/div_step.sv | 25 ++
 rtl/div_iter.sv | 117 +++++++++++
 tb/tb_div_iter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the MultDiv unit
package multdiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/adder_32.sv
// rtl/adder_32.sv - two's-complement adder with subtract control
module adder_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  // Subtract as a + ~b + 1 so a single carry chain serves both operations.
  assign sum = a + (sub ? ~b : b) + {{(WIDTH-1){1'b0}}, sub};

endmodule

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] pr_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [2*WIDTH:0] pr_out
);

  logic [WIDTH+1:0] upper;
  logic [WIDTH+1:0] diff;

  // upper is the remainder half after the left shift, with one guard bit for the sign.
  assign upper = pr_in[2*WIDTH:WIDTH-1];
  assign diff  = upper - {2'b00, dvs};

  always_comb begin
    if (!diff[WIDTH+1]) begin
      pr_out = {diff[WIDTH:0], pr_in[WIDTH-2:0], 1'b1};
    end else begin
      pr_out = {upper[WIDTH:0], pr_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative signed restoring divider with divide-by-zero flag
module div_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = multdiv_pkg::WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             exception,
  output logic             ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic             sign_q, sign_r;
  logic [2*WIDTH:0] pr_q, pr_d;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;

  logic ready_d, busy_d, step_en, fix_en;
  logic div_zero;

  logic [WIDTH-1:0] neg_dvd, neg_dvs, neg_quo, neg_rem;
  logic [WIDTH-1:0] abs_dvd, abs_dvs;

  assign div_zero = (divisor == '0);

  adder_32 #(.WIDTH(WIDTH)) u_neg_dvd (.a('0), .b(dividend),              .sub(1'b1), .sum(neg_dvd));
  adder_32 #(.WIDTH(WIDTH)) u_neg_dvs (.a('0), .b(divisor),               .sub(1'b1), .sum(neg_dvs));
  adder_32 #(.WIDTH(WIDTH)) u_neg_quo (.a('0), .b(pr_q[WIDTH-1:0]),       .sub(1'b1), .sum(neg_quo));
  adder_32 #(.WIDTH(WIDTH)) u_neg_rem (.a('0), .b(pr_q[2*WIDTH-1:WIDTH]), .sub(1'b1), .sum(neg_rem));

  // MIN_INT negates to itself, which is exactly its magnitude read as unsigned.
  assign abs_dvd = dividend[WIDTH-1] ? neg_dvd : dividend;
  assign abs_dvs = divisor[WIDTH-1]  ? neg_dvs : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .pr_in  (pr_q),
    .dvs    (dvs_q),
    .pr_out (pr_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A start always wins, so a busy divider restarts with the new operands.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = div_zero ? DONE : RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (cnt_q == LAST_CNT) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    step_en = !start && (state_q == RUN);
    fix_en  = !start && (state_q == FIX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready     <= 1'b0;
      busy      <= 1'b0;
      exception <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      pr_q      <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
    end else begin
      ready <= ready_d;
      busy  <= busy_d;
      if (start) begin
        sign_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        sign_r    <= dividend[WIDTH-1];
        dvs_q     <= abs_dvs;
        pr_q      <= {{(WIDTH+1){1'b0}}, abs_dvd};
        cnt_q     <= '0;
        quotient  <= '0;
        remainder <= '0;
        exception <= div_zero;
      end else if (step_en) begin
        pr_q  <= pr_d;
        cnt_q <= cnt_q + 1'b1;
      end else if (fix_en) begin
        quotient  <= sign_q ? neg_quo : pr_q[WIDTH-1:0];
        remainder <= sign_r ? neg_rem : pr_q[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - self-checking bench for div_iter against an arithmetic model
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient, remainder;
  logic        exception, ready, busy;

  int tests = 0;
  int fails = 0;

  div_iter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .exception (exception),
    .ready     (ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic e);
    longint sa, sb;
    if (b == 32'd0) begin
      q = '0; r = '0; e = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      e  = 1'b0;
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                        output logic [31:0] q, output logic [31:0] r, output logic e,
                        output logic busy_ok);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_ok = 1'b1; q = 'x; r = 'x; e = 1'bx;
    for (int i = 1; i <= 50; i++) begin
      if (i > 1) begin
        @(posedge clk); #1;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (ready === 1'b1) begin
        lat = i; q = quotient; r = remainder; e = exception;
        break;
      end
    end
  endtask

  task automatic op_check(input string name, input logic [31:0] a, input logic [31:0] b);
    int lat, exp_lat;
    logic [31:0] q, r, eq, er;
    logic e, ee, bok;
    model(a, b, eq, er, ee);
    exp_lat = (b == 32'd0) ? 1 : 34;
    run_op(a, b, lat, q, r, e, bok);
    tests++;
    if (lat !== exp_lat) begin
      fails++; $display("FAIL %s latency: got %0d expected %0d (a=%h b=%h)", name, lat, exp_lat, a, b);
    end
    tests++;
    if ({q, r, e} !== {eq, er, ee}) begin
      fails++; $display("FAIL %s result: got q=%h r=%h e=%b expected q=%h r=%h e=%b (a=%h b=%h)",
                        name, q, r, e, eq, er, ee, a, b);
    end
    tests++;
    if (bok !== 1'b1) begin
      fails++; $display("FAIL %s busy: got busy low before ready, expected high (a=%h b=%h)", name, a, b);
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({ready, busy, exception, quotient, remainder} !== 67'd0) begin
      fails++; $display("FAIL reset_state: got ready=%b busy=%b exc=%b q=%h r=%h expected all zero",
                        ready, busy, exception, quotient, remainder);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_signs();
    op_check("pos_pos", 32'd100, 32'd7);
    @(posedge clk); #1;
    tests++;
    if ({ready, busy} !== 2'b00) begin
      fails++; $display("FAIL ready_pulse_width: got ready=%b busy=%b expected 0 0", ready, busy);
    end
    tests++;
    if ({quotient, remainder} !== {32'd14, 32'd2}) begin
      fails++; $display("FAIL result_hold: got q=%h r=%h expected q=%h r=%h", quotient, remainder, 32'd14, 32'd2);
    end
    op_check("neg_pos", 32'hFFFF_FF9C, 32'd7);
    op_check("pos_neg", 32'd100, 32'hFFFF_FFF9);
    op_check("neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9);
  endtask

  task automatic test_div_zero();
    op_check("div_zero", 32'd1234, 32'd0);
    op_check("after_zero", 32'd8, 32'd2);
  endtask

  task automatic test_overflow();
    op_check("overflow", 32'h8000_0000, 32'hFFFF_FFFF);
    op_check("min_by_min", 32'h8000_0000, 32'h8000_0000);
    op_check("small_by_min", 32'd5, 32'h8000_0000);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 15));
        1:       b = -32'($urandom_range(1, 300));
        2:       b = $urandom;
        default: b = (i % 6 == 0) ? 32'd0 : 32'($urandom_range(1, 65535));
      endcase
      op_check("random", a, b);
    end
  endtask

  task automatic test_restart();
    int early = 0;
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (ready === 1'b1) early++;
      @(posedge clk); #1;
    end
    tests++;
    if (early != 0) begin
      fails++; $display("FAIL restart_early_ready: got %0d ready cycles expected 0", early);
    end
    op_check("restart", 32'd50, 32'd5);
  endtask

  task automatic test_async_reset();
    int spurious = 0;
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    tests++;
    if ({ready, busy, exception, quotient} !== 34'd0) begin
      fails++; $display("FAIL async_reset: got ready=%b busy=%b exc=%b q=%h expected all zero",
                        ready, busy, exception, quotient);
    end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready === 1'b1 || busy === 1'b1) spurious++;
    end
    tests++;
    if (spurious != 0) begin
      fails++; $display("FAIL post_reset_idle: got %0d ready/busy cycles expected 0", spurious);
    end
    op_check("after_reset", 32'd1000, 32'hFFFF_FFFD);
  endtask

  initial begin
    test_reset();
    test_signs();
    test_div_zero();
    test_overflow();
    test_random();
    test_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
